cpl_tag_tracker: RTL and testbench

//  Tracks outstanding non-posted PCIe memory-read requests by tag, on the completion side of the tag allocator.

---
 rtl/cpl_tag_tracker.sv | 207 ++++++++++++++++++++
 tb/tb_cpl_tag_tracker.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpl_tag_tracker.sv
// Completion-side tag tracker: per-tag outstanding-read table with payload accounting and errors.
// Optional per-tag completion timeout is enabled by defining CPL_TIMEOUT_EN.
module cpl_tag_tracker #(
  parameter int unsigned TAG_W     = 5,
  parameter int unsigned TICK_DIV  = 1024,
  parameter int unsigned TMO_TICKS = 15
) (
  input  logic             trn_clk,
  input  logic             reset,
  input  logic             i_req_valid,
  input  logic [TAG_W-1:0] i_req_tag,
  input  logic [9:0]       i_req_len_dw,
  input  logic             i_cpl_valid,
  input  logic [TAG_W-1:0] i_cpl_tag,
  input  logic [9:0]       i_cpl_len_dw,
  input  logic [2:0]       i_cpl_status,
  output logic             o_full,
  output logic [TAG_W:0]   o_outstanding,
  output logic             o_done_valid,
  output logic [TAG_W-1:0] o_done_tag,
  output logic             o_err_valid,
  output logic [TAG_W-1:0] o_err_tag,
  output logic [2:0]       o_err_code
);

  localparam int unsigned NENT = 2 ** TAG_W;
  localparam logic [TAG_W:0] FULL_CNT = (TAG_W + 1)'(NENT);

  localparam logic [2:0] ERR_DUP     = 3'd1;
  localparam logic [2:0] ERR_UNEXP   = 3'd2;
  localparam logic [2:0] ERR_STATUS  = 3'd3;
  localparam logic [2:0] ERR_OVERRUN = 3'd4;
  localparam logic [2:0] ERR_TIMEOUT = 3'd5;

  logic [NENT-1:0] r_valid;
  logic [10:0]     r_rem [NENT];
  logic [TAG_W:0]  r_outstanding;
  logic            r_full;
  logic            r_done_valid;
  logic [TAG_W-1:0] r_done_tag;
  logic            r_err_valid;
  logic [TAG_W-1:0] r_err_tag;
  logic [2:0]      r_err_code;

  logic [10:0]     w_req_len;
  logic [10:0]     w_cpl_len;
  logic [10:0]     w_cpl_rem;
  logic            w_cpl_hit;
  logic            w_cpl_free;
  logic            w_cpl_done;
  logic            w_cpl_part;
  logic            w_cpl_err;
  logic [2:0]      w_cpl_code;
  logic            w_alloc;
  logic            w_dup;
  logic            w_tmo_fire;
  logic [TAG_W-1:0] w_tmo_tag;
  logic [TAG_W:0]  w_out_nxt;

  // Completion and alloc are both judged against the pre-cycle table.
  always_comb begin
    w_req_len  = (i_req_len_dw == 10'd0) ? 11'd1024 : {1'b0, i_req_len_dw};
    w_cpl_len  = (i_cpl_len_dw == 10'd0) ? 11'd1024 : {1'b0, i_cpl_len_dw};
    w_cpl_hit  = r_valid[i_cpl_tag];
    w_cpl_rem  = r_rem[i_cpl_tag];
    w_cpl_free = 1'b0;
    w_cpl_done = 1'b0;
    w_cpl_part = 1'b0;
    w_cpl_err  = 1'b0;
    w_cpl_code = 3'd0;
    if (i_cpl_valid) begin
      if (!w_cpl_hit) begin
        w_cpl_err  = 1'b1;
        w_cpl_code = ERR_UNEXP;
      end else if (i_cpl_status != 3'b000) begin
        w_cpl_free = 1'b1;
        w_cpl_err  = 1'b1;
        w_cpl_code = ERR_STATUS;
      end else if (w_cpl_len > w_cpl_rem) begin
        w_cpl_free = 1'b1;
        w_cpl_err  = 1'b1;
        w_cpl_code = ERR_OVERRUN;
      end else if (w_cpl_len == w_cpl_rem) begin
        w_cpl_free = 1'b1;
        w_cpl_done = 1'b1;
      end else begin
        w_cpl_part = 1'b1;
      end
    end
    w_alloc = i_req_valid && !r_valid[i_req_tag];
    w_dup   = i_req_valid && r_valid[i_req_tag];
  end

`ifdef CPL_TIMEOUT_EN
  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
  localparam logic [3:0] TMO_AGE = 4'(TMO_TICKS);

  logic [PRESC_W-1:0] r_presc;
  logic [3:0]         r_age [NENT];
  logic               w_tick;
  logic               w_tmo_hit;

  assign w_tick = (r_presc == PRESC_MAX);

  // Lowest expired entry; an entry touched by a good completion this cycle is left to it.
  always_comb begin
    w_tmo_hit = 1'b0;
    w_tmo_tag = '0;
    for (int i = 0; i < NENT; i++) begin
      if (!w_tmo_hit && r_valid[i] && (r_age[i] == TMO_AGE) &&
          !(i_cpl_valid && w_cpl_hit && (i_cpl_tag == TAG_W'(i)))) begin
        w_tmo_hit = 1'b1;
        w_tmo_tag = TAG_W'(i);
      end
    end
    w_tmo_fire = w_tmo_hit && !w_cpl_err;
  end

  always_ff @(posedge trn_clk) begin
    if (reset) begin
      r_presc <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
    end
  end

  always_ff @(posedge trn_clk) begin
    for (int i = 0; i < NENT; i++) begin
      if (w_alloc && (i_req_tag == TAG_W'(i))) begin
        r_age[i] <= 4'd0;
      end else if (w_cpl_part && (i_cpl_tag == TAG_W'(i))) begin
        r_age[i] <= 4'd0;
      end else if (w_tick && (r_age[i] != TMO_AGE)) begin
        r_age[i] <= r_age[i] + 4'd1;
      end
    end
  end
`else
  assign w_tmo_fire = 1'b0;
  assign w_tmo_tag  = '0;
`endif

  assign w_out_nxt = r_outstanding + {{TAG_W{1'b0}}, w_alloc}
                   - {{TAG_W{1'b0}}, w_cpl_free} - {{TAG_W{1'b0}}, w_tmo_fire};

  // Remaining-DW table carries no reset; an entry's count is loaded on alloc.
  always_ff @(posedge trn_clk) begin
    for (int i = 0; i < NENT; i++) begin
      if (w_alloc && (i_req_tag == TAG_W'(i))) begin
        r_rem[i] <= w_req_len;
      end else if (w_cpl_part && (i_cpl_tag == TAG_W'(i))) begin
        r_rem[i] <= r_rem[i] - w_cpl_len;
      end
    end
  end

  always_ff @(posedge trn_clk) begin
    if (reset) begin
      r_valid       <= '0;
      r_outstanding <= '0;
      r_full        <= 1'b0;
      r_done_valid  <= 1'b0;
      r_done_tag    <= '0;
      r_err_valid   <= 1'b0;
      r_err_tag     <= '0;
      r_err_code    <= 3'd0;
    end else begin
      for (int i = 0; i < NENT; i++) begin
        if (w_alloc && (i_req_tag == TAG_W'(i))) begin
          r_valid[i] <= 1'b1;
        end else if (w_cpl_free && (i_cpl_tag == TAG_W'(i))) begin
          r_valid[i] <= 1'b0;
        end else if (w_tmo_fire && (w_tmo_tag == TAG_W'(i))) begin
          r_valid[i] <= 1'b0;
        end
      end
      r_outstanding <= w_out_nxt;
      r_full        <= (w_out_nxt == FULL_CNT);
      r_done_valid  <= w_cpl_done;
      if (w_cpl_done) begin
        r_done_tag <= i_cpl_tag;
      end
      // One error per cycle: completion error, then timeout, then dup alloc.
      r_err_valid <= w_cpl_err || w_tmo_fire || w_dup;
      if (w_cpl_err) begin
        r_err_tag  <= i_cpl_tag;
        r_err_code <= w_cpl_code;
      end else if (w_tmo_fire) begin
        r_err_tag  <= w_tmo_tag;
        r_err_code <= ERR_TIMEOUT;
      end else if (w_dup) begin
        r_err_tag  <= i_req_tag;
        r_err_code <= ERR_DUP;
      end
    end
  end

  assign o_full        = r_full;
  assign o_outstanding = r_outstanding;
  assign o_done_valid  = r_done_valid;
  assign o_done_tag    = r_done_tag;
  assign o_err_valid   = r_err_valid;
  assign o_err_tag     = r_err_tag;
  assign o_err_code    = r_err_code;

endmodule

// File: tb/tb_cpl_tag_tracker.sv
// Bench for cpl_tag_tracker: directed vector table, corner sequences, random run against a model.
// With CPL_TIMEOUT_EN defined it runs the timeout sequence on a short-tick instance instead.
module tb_cpl_tag_tracker;

  localparam int TAG_W = 5;
  localparam int NENT  = 32;
`ifdef CPL_TIMEOUT_EN
  localparam int TICK_DIV  = 4;
  localparam int TMO_TICKS = 2;
`else
  localparam int TICK_DIV  = 1024;
  localparam int TMO_TICKS = 15;
`endif

  logic             trn_clk = 1'b0;
  logic             reset = 1'b1;
  logic             i_req_valid = 1'b0;
  logic [TAG_W-1:0] i_req_tag = '0;
  logic [9:0]       i_req_len_dw = '0;
  logic             i_cpl_valid = 1'b0;
  logic [TAG_W-1:0] i_cpl_tag = '0;
  logic [9:0]       i_cpl_len_dw = '0;
  logic [2:0]       i_cpl_status = '0;
  logic             o_full;
  logic [TAG_W:0]   o_outstanding;
  logic             o_done_valid;
  logic [TAG_W-1:0] o_done_tag;
  logic             o_err_valid;
  logic [TAG_W-1:0] o_err_tag;
  logic [2:0]       o_err_code;

  cpl_tag_tracker #(
    .TAG_W    (TAG_W),
    .TICK_DIV (TICK_DIV),
    .TMO_TICKS(TMO_TICKS)
  ) dut (
    .trn_clk      (trn_clk),
    .reset        (reset),
    .i_req_valid  (i_req_valid),
    .i_req_tag    (i_req_tag),
    .i_req_len_dw (i_req_len_dw),
    .i_cpl_valid  (i_cpl_valid),
    .i_cpl_tag    (i_cpl_tag),
    .i_cpl_len_dw (i_cpl_len_dw),
    .i_cpl_status (i_cpl_status),
    .o_full       (o_full),
    .o_outstanding(o_outstanding),
    .o_done_valid (o_done_valid),
    .o_done_tag   (o_done_tag),
    .o_err_valid  (o_err_valid),
    .o_err_tag    (o_err_tag),
    .o_err_code   (o_err_code)
  );

  always #5 trn_clk = ~trn_clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string name;
    bit    rv;
    int    rtag;
    int    rlen;
    bit    cv;
    int    ctag;
    int    clen;
    int    cst;
    bit    e_done;
    int    e_dtag;
    bit    e_err;
    int    e_etag;
    int    e_code;
    int    e_out;
  } vec_t;

  function automatic vec_t mk(string name, bit rv, int rtag, int rlen, bit cv, int ctag,
                              int clen, int cst, bit e_done, int e_dtag, bit e_err,
                              int e_etag, int e_code, int e_out);
    vec_t v;
    v.name = name; v.rv = rv; v.rtag = rtag; v.rlen = rlen;
    v.cv = cv; v.ctag = ctag; v.clen = clen; v.cst = cst;
    v.e_done = e_done; v.e_dtag = e_dtag; v.e_err = e_err;
    v.e_etag = e_etag; v.e_code = e_code; v.e_out = e_out;
    return v;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge trn_clk);
    #1;
  endtask

  task automatic drive(input bit rv, input int rtag, input int rlen, input bit cv,
                       input int ctag, input int clen, input int cst);
    i_req_valid  = rv;
    i_req_tag    = TAG_W'(rtag);
    i_req_len_dw = 10'(rlen);
    i_cpl_valid  = cv;
    i_cpl_tag    = TAG_W'(ctag);
    i_cpl_len_dw = 10'(clen);
    i_cpl_status = 3'(cst);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_outs(input string name, input bit e_done, input int e_dtag,
                            input bit e_err, input int e_etag, input int e_code, input int e_out);
    check({name, ".done_valid"}, int'(o_done_valid), int'(e_done));
    if (e_done) check({name, ".done_tag"}, int'(o_done_tag), e_dtag);
    check({name, ".err_valid"}, int'(o_err_valid), int'(e_err));
    if (e_err) begin
      check({name, ".err_code"}, int'(o_err_code), e_code);
      check({name, ".err_tag"}, int'(o_err_tag), e_etag);
    end
    check({name, ".outstanding"}, int'(o_outstanding), e_out);
    check({name, ".full"}, int'(o_full), int'(e_out == NENT));
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Reference model: table of outstanding reads, in plain integers.
  bit m_valid[NENT];
  int m_rem[NENT];

  task automatic model_clear();
    for (int i = 0; i < NENT; i++) begin
      m_valid[i] = 0;
      m_rem[i]   = 0;
    end
  endtask

  task automatic model_step(input bit rv, input int rtag, input int rlen, input bit cv,
                            input int ctag, input int clen, input int cst,
                            output bit e_done, output int e_dtag, output bit e_err,
                            output int e_etag, output int e_code, output int e_out);
    bit alloc_was_valid;
    bit cerr;
    int ccode;
    int clen_dw;
    alloc_was_valid = m_valid[rtag];
    clen_dw = (clen == 0) ? 1024 : clen;
    e_done = 0; e_dtag = 0; cerr = 0; ccode = 0;
    if (cv) begin
      if (!m_valid[ctag]) begin
        cerr = 1; ccode = 2;
      end else if (cst != 0) begin
        cerr = 1; ccode = 3; m_valid[ctag] = 0;
      end else if (clen_dw > m_rem[ctag]) begin
        cerr = 1; ccode = 4; m_valid[ctag] = 0;
      end else if (clen_dw == m_rem[ctag]) begin
        e_done = 1; e_dtag = ctag; m_valid[ctag] = 0;
      end else begin
        m_rem[ctag] -= clen_dw;
      end
    end
    if (rv && !alloc_was_valid) begin
      m_valid[rtag] = 1;
      m_rem[rtag]   = (rlen == 0) ? 1024 : rlen;
    end
    e_err = 0; e_etag = 0; e_code = 0;
    if (cerr) begin
      e_err = 1; e_etag = ctag; e_code = ccode;
    end else if (rv && alloc_was_valid) begin
      e_err = 1; e_etag = rtag; e_code = 1;
    end
    e_out = 0;
    for (int i = 0; i < NENT; i++) e_out += int'(m_valid[i]);
  endtask

  vec_t vecs[20];

  initial begin
    vecs[0]  = mk("t1_alloc3",      1, 3, 16,   0, 0, 0, 0,      0, 0,  0, 0, 0, 1);
    vecs[1]  = mk("t1_cpl3_a",      0, 0, 0,    1, 3, 8, 0,      0, 0,  0, 0, 0, 1);
    vecs[2]  = mk("t1_cpl3_b",      0, 0, 0,    1, 3, 8, 0,      1, 3,  0, 0, 0, 0);
    vecs[3]  = mk("t2_alloc7",      1, 7, 1,    0, 0, 0, 0,      0, 0,  0, 0, 0, 1);
    vecs[4]  = mk("t2_dup7",        1, 7, 1,    0, 0, 0, 0,      0, 0,  1, 7, 1, 1);
    vecs[5]  = mk("t3_unexp9",      0, 0, 0,    1, 9, 1, 0,      0, 0,  1, 9, 2, 1);
    vecs[6]  = mk("t3_alloc4",      1, 4, 8,    0, 0, 0, 0,      0, 0,  0, 0, 0, 2);
    vecs[7]  = mk("t3_status4",     0, 0, 0,    1, 4, 8, 1,      0, 0,  1, 4, 3, 1);
    vecs[8]  = mk("t4_alloc0",      1, 0, 4,    0, 0, 0, 0,      0, 0,  0, 0, 0, 2);
    vecs[9]  = mk("t4_overrun0",    0, 0, 0,    1, 0, 6, 0,      0, 0,  1, 0, 4, 1);
    vecs[10] = mk("t4_realloc0",    1, 0, 4,    0, 0, 0, 0,      0, 0,  0, 0, 0, 2);
    vecs[11] = mk("len1024_alloc",  1, 10, 0,   0, 0, 0, 0,      0, 0,  0, 0, 0, 3);
    vecs[12] = mk("len1024_part",   0, 0, 0,    1, 10, 1023, 0,  0, 0,  0, 0, 0, 3);
    vecs[13] = mk("len1024_last",   0, 0, 0,    1, 10, 1, 0,     1, 10, 0, 0, 0, 2);
    vecs[14] = mk("cpl1024_alloc",  1, 11, 0,   0, 0, 0, 0,      0, 0,  0, 0, 0, 3);
    vecs[15] = mk("cpl1024_done",   0, 0, 0,    1, 11, 0, 0,     1, 11, 0, 0, 0, 2);
    vecs[16] = mk("same_tag_dup",   1, 7, 1,    1, 7, 1, 0,      1, 7,  1, 7, 1, 1);
    vecs[17] = mk("alloc_plus_unx", 1, 12, 2,   1, 20, 1, 0,     0, 0,  1, 20, 2, 2);
    vecs[18] = mk("cplerr_over_dup",1, 0, 4,    1, 13, 1, 0,     0, 0,  1, 13, 2, 2);
    vecs[19] = mk("idle",           0, 0, 0,    0, 0, 0, 0,      0, 0,  0, 0, 0, 2);
  end

  initial begin
    #2;
    do_reset();
    check_outs("reset", 0, 0, 0, 0, 0, 0);
    check("reset.done_tag", int'(o_done_tag), 0);
    check("reset.err_tag", int'(o_err_tag), 0);
    check("reset.err_code", int'(o_err_code), 0);

`ifdef CPL_TIMEOUT_EN
    begin
      int waited;
      bit seen;
      // Prescaler starts at 0 here, so both allocs land in the same tick window.
      drive(1, 1, 4, 0, 0, 0, 0); tick();
      drive(1, 2, 4, 0, 0, 0, 0); tick();
      idle();
      check_outs("tmo_allocs", 0, 0, 0, 0, 0, 2);
      waited = 0;
      while (!o_err_valid && waited < 40) begin
        tick();
        waited++;
      end
      check_outs("tmo_first", 0, 0, 1, 1, 5, 1);
      tick();
      check_outs("tmo_second", 0, 0, 1, 2, 5, 0);
      tick();
      check_outs("tmo_quiet", 0, 0, 0, 0, 0, 0);
      drive(1, 3, 4, 0, 0, 0, 0); tick();
      idle(); tick(); tick();
      reset = 1'b1; tick(); reset = 1'b0;
      check_outs("tmo_midreset", 0, 0, 0, 0, 0, 0);
      seen = 0;
      for (int k = 0; k < 24; k++) begin
        tick();
        if (o_err_valid) seen = 1;
      end
      check("tmo_after_reset_no_err", int'(seen), 0);
    end
`else
    // Directed vector table.
    foreach (vecs[i]) begin
      drive(vecs[i].rv, vecs[i].rtag, vecs[i].rlen, vecs[i].cv, vecs[i].ctag,
            vecs[i].clen, vecs[i].cst);
      tick();
      check_outs(vecs[i].name, vecs[i].e_done, vecs[i].e_dtag, vecs[i].e_err,
                 vecs[i].e_etag, vecs[i].e_code, vecs[i].e_out);
    end

    // Fill the table, then same-cycle alloc + final completion on the same tag.
    do_reset();
    for (int t = 0; t < NENT; t++) begin
      drive(1, t, 1, 0, 0, 0, 0);
      tick();
      if (t == NENT - 2) check_outs("fill_31", 0, 0, 0, 0, 0, NENT - 1);
    end
    check_outs("fill_32", 0, 0, 0, 0, 0, NENT);
    drive(1, 5, 1, 1, 5, 1, 0); tick();
    check_outs("full_same5", 1, 5, 1, 5, 1, NENT - 1);
    drive(1, 5, 2, 0, 0, 0, 0); tick();
    check_outs("refill5", 0, 0, 0, 0, 0, NENT);
    drive(1, 9, 2, 0, 0, 0, 0); tick();
    check_outs("req_while_full", 0, 0, 1, 9, 1, NENT);
    idle();
    reset = 1'b1; tick(); reset = 1'b0;
    check_outs("midreset", 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 5, 1, 0); tick();
    check_outs("after_reset_cpl5", 0, 0, 1, 5, 2, 0);

    // Random traffic against the model.
    do_reset();
    model_clear();
    for (int n = 0; n < 3000; n++) begin
      bit rv, cv, e_done, e_err;
      int rtag, rlen, ctag, clen, cst, e_dtag, e_etag, e_code, e_out;
      rv   = ($urandom % 2) == 0;
      rtag = $urandom % NENT;
      rlen = (($urandom % 16) == 0) ? 0 : int'($urandom_range(1, 6));
      cv   = ($urandom % 3) != 0;
      ctag = $urandom % NENT;
      if (($urandom % 4) != 0) begin
        int s;
        s = $urandom % NENT;
        for (int k = 0; k < NENT; k++) begin
          if (m_valid[(s + k) % NENT]) begin
            ctag = (s + k) % NENT;
            break;
          end
        end
      end
      clen = int'($urandom_range(1, 4));
      cst  = (($urandom % 16) == 0) ? int'($urandom_range(1, 7)) : 0;
      drive(rv, rtag, rlen, cv, ctag, clen, cst);
      model_step(rv, rtag, rlen, cv, ctag, clen, cst,
                 e_done, e_dtag, e_err, e_etag, e_code, e_out);
      tick();
      check_outs("rand", e_done, e_dtag, e_err, e_etag, e_code, e_out);
    end
    idle();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
